// File: rtl/nf_bin2bcd_seq.sv
// nf_bin2bcd_seq: one-bit-per-clock double-dabble binary-to-BCD converter with leading-zero blank mask
module nf_bin2bcd_seq #(
  parameter int BIN_W = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [BIN_W-1:0] bin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [31:0]      bcd_o,
  output logic [7:0]       blank_o
);
  localparam int CW = $clog2(BIN_W + 1);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BIN_W-1:0] shreg_q, shreg_d, sh_reg;
  logic [31:0]      work_q, work_d, adj, sh_work, bcd_q;
  logic [7:0]       blank_q, blank_d;
  logic             done_q, fin;

  always_comb begin
    for (int i = 0; i < 8; i++)
      adj[4*i+:4] = work_q[4*i+:4] >= 4'd5 ? work_q[4*i+:4] + 4'd3 : work_q[4*i+:4];
    {sh_work, sh_reg} = {adj[30:0], shreg_q, 1'b0};
    fin = state_q == SHIFT && cnt_q == CW'(1);
    // blank bit i is set while every digit from i upward is zero
    blank_d[7] = sh_work[31:28] == 4'd0;
    for (int i = 6; i >= 1; i--)
      blank_d[i] = blank_d[i+1] && sh_work[4*i+:4] == 4'd0;
    blank_d[0] = 1'b0;
    state_d = state_q == IDLE ? (start_i ? SHIFT : IDLE) : (fin ? IDLE : SHIFT);
    shreg_d = state_q == IDLE ? (start_i ? bin_i : shreg_q) : sh_reg;
    work_d  = state_q == IDLE ? (start_i ? 32'd0 : work_q) : sh_work;
    cnt_d   = state_q == IDLE ? (start_i ? CW'(BIN_W) : cnt_q) : cnt_q - CW'(1);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      work_q  <= '0;
      bcd_q   <= '0;
      blank_q <= 8'hFE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      work_q  <= work_d;
      done_q  <= fin;
      if (fin) begin
        bcd_q   <= sh_work;
        blank_q <= blank_d;
      end
    end
  end

  assign busy_o  = state_q == SHIFT;
  assign done_o  = done_q;
  assign bcd_o   = bcd_q;
  assign blank_o = blank_q;
endmodule

// File: tb/tb_nf_bin2bcd_seq.sv
// tb_nf_bin2bcd_seq: directed vector table, multi-cycle corner sequences and random sweep for 16- and 26-bit converters
module tb_nf_bin2bcd_seq;
  logic        clk = 0, rst = 1, st16 = 0, st26 = 0;
  logic [15:0] bin16 = '0;
  logic [25:0] bin26 = '0;
  logic        busy16, done16, busy26, done26;
  logic [31:0] bcd16, bcd26;
  logic [7:0]  bl16, bl26;
  int          checks = 0, errors = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nf_bin2bcd_seq #(.BIN_W(16)) dut16 (.clk_i(clk), .reset_i(rst), .start_i(st16), .bin_i(bin16),
    .busy_o(busy16), .done_o(done16), .bcd_o(bcd16), .blank_o(bl16));
  nf_bin2bcd_seq #(.BIN_W(26)) dut26 (.clk_i(clk), .reset_i(rst), .start_i(st26), .bin_i(bin26),
    .busy_o(busy26), .done_o(done26), .bcd_o(bcd26), .blank_o(bl26));

  typedef struct {logic w26; logic [25:0] bin; logic [31:0] bcd; logic [7:0] blank;} vec_t;
  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_bcd(input int unsigned v);
    logic [31:0] r = '0;
    for (int i = 0; i < 8; i++) begin
      r[4*i+:4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [7:0] ref_blank(input logic [31:0] b);
    logic [7:0] m = '0;
    bit z = 1;
    for (int i = 7; i >= 1; i--) begin
      z = z && b[4*i+:4] == 4'd0;
      m[i] = z;
    end
    return m;
  endfunction

  task automatic conv(input logic w, input logic [25:0] b, input logic [31:0] eb, input logic [7:0] ebl, input string name);
    int n = 0, t = 0;
    @(negedge clk);
    if (w) begin st26 = 1; bin26 = b; end
    else begin st16 = 1; bin16 = b[15:0]; end
    @(negedge clk);
    st16 = 0; st26 = 0;
    while (!(w ? done26 : done16) && t < 40) begin
      t++;
      if (w ? busy26 : busy16) n++;
      @(negedge clk);
    end
    chk({name, " done"}, 32'(w ? done26 : done16), 1);
    chk({name, " busy_cycles"}, n, w ? 26 : 16);
    chk({name, " bcd"}, w ? bcd26 : bcd16, eb);
    chk({name, " blank"}, 32'(w ? bl26 : bl16), 32'(ebl));
    @(negedge clk);
    chk({name, " done_width"}, 32'(w ? done26 : done16), 0);
  endtask

  initial begin
    int ndone, t, td[3];
    logic [25:0] v;
    vecs[0]  = '{1'b0, 26'd0,        32'h0000_0000, 8'hFE};
    vecs[1]  = '{1'b0, 26'd1234,     32'h0000_1234, 8'hF0};
    vecs[2]  = '{1'b0, 26'd65535,    32'h0006_5535, 8'hE0};
    vecs[3]  = '{1'b0, 26'd9,        32'h0000_0009, 8'hFE};
    vecs[4]  = '{1'b0, 26'd10,       32'h0000_0010, 8'hFC};
    vecs[5]  = '{1'b0, 26'd99,       32'h0000_0099, 8'hFC};
    vecs[6]  = '{1'b0, 26'd100,      32'h0000_0100, 8'hF8};
    vecs[7]  = '{1'b0, 26'd4321,     32'h0000_4321, 8'hF0};
    vecs[8]  = '{1'b1, 26'd67108863, 32'h6710_8863, 8'h00};
    vecs[9]  = '{1'b1, 26'd0,        32'h0000_0000, 8'hFE};
    vecs[10] = '{1'b1, 26'd10000000, 32'h1000_0000, 8'h00};

    repeat (3) @(negedge clk);
    rst = 0;
    repeat (2) @(negedge clk);
    chk("rst bcd", bcd16, 0);
    chk("rst blank", 32'(bl16), 32'hFE);
    chk("rst busy", 32'(busy16), 0);
    chk("rst done", 32'(done16), 0);
    chk("rst26 blank", 32'(bl26), 32'hFE);

    for (int i = 0; i < 11; i++)
      conv(vecs[i].w26, vecs[i].bin, vecs[i].bcd, vecs[i].blank, $sformatf("vec%0d", i));

    // restart attempt mid-conversion must be ignored
    @(negedge clk); st16 = 1; bin16 = 16'd1234;
    @(negedge clk); st16 = 0;
    repeat (5) @(negedge clk);
    st16 = 1; bin16 = 16'd5678;
    @(negedge clk); st16 = 0;
    ndone = 0;
    repeat (40) begin
      if (done16) ndone++;
      @(negedge clk);
    end
    chk("midstart ndone", ndone, 1);
    chk("midstart bcd", bcd16, 32'h0000_1234);
    chk("midstart busy", 32'(busy16), 0);

    // start held high: back-to-back conversions every 17 cycles
    @(negedge clk); st16 = 1; bin16 = 16'd111;
    for (int k = 0; k < 3; k++) begin
      t = 0;
      @(negedge clk);
      while (!done16 && t < 40) begin t++; @(negedge clk); end
      td[k] = cyc;
      chk($sformatf("held done%0d", k), 32'(done16), 1);
      chk($sformatf("held bcd%0d", k), bcd16, ref_bcd(111 * (k + 1)));
      if (k < 2) bin16 = 16'(111 * (k + 2));
      else st16 = 0;
    end
    chk("held period1", td[1] - td[0], 17);
    chk("held period2", td[2] - td[1], 17);

    // reset during shift 8 of 4321
    @(negedge clk); st16 = 1; bin16 = 16'd4321;
    @(negedge clk); st16 = 0;
    repeat (7) @(negedge clk);
    rst = 1;
    #1;
    chk("midrst bcd", bcd16, 0);
    chk("midrst blank", 32'(bl16), 32'hFE);
    chk("midrst busy", 32'(busy16), 0);
    chk("midrst done", 32'(done16), 0);
    @(negedge clk); rst = 0;
    ndone = 0;
    repeat (30) begin
      @(negedge clk);
      if (done16 || busy16) ndone++;
    end
    chk("midrst no_done", ndone, 0);
    conv(1'b0, 26'd4321, 32'h0000_4321, 8'hF0, "after_rst");

    for (int i = 0; i < 1000; i++) begin
      v = 26'($urandom_range(0, 65535));
      conv(1'b0, v, ref_bcd(int'(v)), ref_blank(ref_bcd(int'(v))), "rnd16");
    end
    for (int i = 0; i < 1000; i++) begin
      v = 26'($urandom_range(0, 67108863));
      conv(1'b1, v, ref_bcd(int'(v)), ref_blank(ref_bcd(int'(v))), "rnd26");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
